control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/nsc8_pkg.sv | 54 +++++
 rtl/control_decode.sv | 75 +++++++
 rtl/control_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/nsc8_pkg.sv
// Shared definitions for the NSC-8 control path: state encodings,
// opcode constants, the control-strobe bundle and instruction step counts.
package nsc8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_EXEC3  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One bit per control line; the first five are the bus drivers.
  typedef struct packed {
    logic pc_out_enable;
    logic ram_output_enable;
    logic ir_out_enable;
    logic output_enable;
    logic alu_output_enable;
    logic mar_load;
    logic ir_load;
    logic load_a;
    logic load_immediate_a;
    logic load_b;
    logic ram_write;
    logic pc_load;
    logic out_load;
    logic pc_enable;
    logic alu_sub;
    logic halted;
  } ctrl_t;

  // Number of EXEC states an opcode occupies before returning to FETCH0.
  function automatic logic [1:0] exec_steps(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return 2'd2;
      OP_ADD, OP_SUB: return 2'd3;
      default:        return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational micro-step decoder: (state, opcode) -> control strobes.
module control_decode
  import nsc8_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Strobes for the current micro-step; everything idles low unless named.
  always_comb begin
    // NOTE: assigning a default to every output before the case keeps
    // unlisted paths from holding their old value, which would infer latches.
    ctrl = '0;
    case (state)
      ST_FETCH0: begin
        ctrl.pc_out_enable = 1'b1;
        ctrl.mar_load      = 1'b1;
      end
      ST_FETCH1: begin
        ctrl.ram_output_enable = 1'b1;
        ctrl.ir_load           = 1'b1;
        ctrl.pc_enable         = 1'b1;
      end
      ST_EXEC1: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out_enable = 1'b1;
            ctrl.mar_load      = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out_enable    = 1'b1;
            ctrl.load_immediate_a = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out_enable = 1'b1;
            ctrl.pc_load       = 1'b1;
          end
          OP_OUT: begin
            ctrl.output_enable = 1'b1;
            ctrl.out_load      = 1'b1;
          end
          default: ;  // NOP, HLT and undefined opcodes idle for one cycle
        endcase
      end
      ST_EXEC2: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_output_enable = 1'b1;
            ctrl.load_a            = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_output_enable = 1'b1;
            ctrl.load_b            = 1'b1;
          end
          OP_STA: begin
            ctrl.output_enable = 1'b1;
            ctrl.ram_write     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC3: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_output_enable = 1'b1;
          ctrl.load_a            = 1'b1;
          ctrl.alu_sub           = (opcode == OP_SUB);
        end
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// NSC-8 Moore control sequencer: holds the state register and the
// instruction register, and fans the decoded strobe bundle out to ports.
module control_sequencer
  import nsc8_pkg::*;
#(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [X-1:0] instr_in,
  output logic         pc_out_enable,
  output logic         ram_output_enable,
  output logic         ir_out_enable,
  output logic         output_enable,
  output logic         alu_output_enable,
  output logic         mar_load,
  output logic         ir_load,
  output logic         load_a,
  output logic         load_immediate_a,
  output logic         load_b,
  output logic         ram_write,
  output logic         pc_load,
  output logic         out_load,
  output logic         pc_enable,
  output logic         alu_sub,
  output logic         halted,
  output logic [2:0]   state_out
);

  state_t     state;
  state_t     state_next;
  logic [X-1:0] ir;
  logic [3:0] opcode;
  logic [1:0] steps;
  ctrl_t      ctrl;
  logic       unused_operand;

  assign opcode = ir[X-1:X-4];
  assign steps  = exec_steps(opcode);

  // The operand nibble only ever reaches the bus through the IR itself.
  assign unused_operand = ^ir[X-5:0];

  // State register; reset drops straight to IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Instruction register captures the data bus at the end of FETCH1 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ir <= '0;
    else if (state == ST_FETCH1) ir <= instr_in;
  end

  // Next-state sequencing; the opcode's step count decides where EXEC ends.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:   state_next = ST_FETCH0;
      ST_FETCH0: state_next = ST_FETCH1;
      ST_FETCH1: state_next = ST_EXEC1;
      ST_EXEC1: begin
        if (opcode == OP_HLT)     state_next = ST_HALT;
        else if (steps == 2'd1)   state_next = ST_FETCH0;
        else                      state_next = ST_EXEC2;
      end
      ST_EXEC2:  state_next = (steps == 2'd2) ? ST_FETCH0 : ST_EXEC3;
      ST_EXEC3:  state_next = ST_FETCH0;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_IDLE;
    endcase
  end

  control_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign pc_out_enable     = ctrl.pc_out_enable;
  assign ram_output_enable = ctrl.ram_output_enable;
  assign ir_out_enable     = ctrl.ir_out_enable;
  assign output_enable     = ctrl.output_enable;
  assign alu_output_enable = ctrl.alu_output_enable;
  assign mar_load          = ctrl.mar_load;
  assign ir_load           = ctrl.ir_load;
  assign load_a            = ctrl.load_a;
  assign load_immediate_a  = ctrl.load_immediate_a;
  assign load_b            = ctrl.load_b;
  assign ram_write         = ctrl.ram_write;
  assign pc_load           = ctrl.pc_load;
  assign out_load          = ctrl.out_load;
  assign pc_enable         = ctrl.pc_enable;
  assign alu_sub           = ctrl.alu_sub;
  assign halted            = ctrl.halted;
  assign state_out         = state;

endmodule
